ccff_bitstream_loader: RTL and testbench

- Word-to-serial configuration loader that sits directly upstream of a tile's configuration chain and drives its ccff_head.
- Accepts bitstream words over a valid/ready interface and shifts exactly CHAIN_LEN bits into the chain, one bit per enabled prog_clk cycle.
- Monitors ccff_tail while shifting, checks the word framing, and reports done and error status to the configuration controller.

---
 rtl/ccff_bitstream_loader.sv | 135 +++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_bitstream_loader.sv
// Word-to-serial loader: takes bitstream words over valid/ready and shifts exactly
// CHAIN_LEN bits (LSB first) into a configuration chain, reporting done and framing/tail errors.
module ccff_bitstream_loader #(
   parameter int DATA_WIDTH = 32,
   parameter int CHAIN_LEN  = 36,
   parameter int CNT_W      = 16
) (
   input  logic                  prog_clk,
   input  logic                  pReset,
   input  logic                  start,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [DATA_WIDTH-1:0] cfg_data,
   input  logic                  cfg_last,
   output logic                  ccff_head,
   output logic                  chain_en,
   input  logic                  ccff_tail,
   output logic                  busy,
   output logic                  done,
   output logic                  err_len,
   output logic                  err_tail,
   output logic [CNT_W-1:0]      bit_cnt
);

   localparam int WCNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0]  CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
   localparam logic [WCNT_W-1:0] WORD_LEN_C  = WCNT_W'(DATA_WIDTH);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_WORD = 2'd1,
      S_SHIFT     = 2'd2,
      S_DONE      = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [WCNT_W-1:0]     word_cnt_q, word_cnt_d;
   logic                  last_q, last_d;
   logic                  err_len_q, err_len_d;
   logic                  err_tail_q, err_tail_d;
   logic                  head_q, head_d;
   logic                  en_q, en_d;

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      word_cnt_d = word_cnt_q;
      last_d     = last_q;
      err_len_d  = err_len_q;
      err_tail_d = err_tail_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               bit_cnt_d  = '0;
               err_len_d  = 1'b0;
               err_tail_d = 1'b0;
               state_d    = S_WAIT_WORD;
            end
         end
         S_WAIT_WORD: begin
            if (cfg_valid) begin
               shreg_d    = cfg_data;
               last_d     = cfg_last;
               word_cnt_d = '0;
               state_d    = S_SHIFT;
            end
         end
         S_SHIFT: begin
            shreg_d    = shreg_q >> 1;
            word_cnt_d = word_cnt_q + WCNT_W'(1);
            if (bit_cnt_q != CHAIN_LEN_C) begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
            // chain was reset to zeros, so any 1 reaching the tail means a bad chain
            if (ccff_tail) begin
               err_tail_d = 1'b1;
            end
            if (bit_cnt_d == CHAIN_LEN_C) begin
               err_len_d = err_len_q | ~last_q;
               state_d   = S_DONE;
            end else if (word_cnt_d == WORD_LEN_C) begin
               if (last_q) begin
                  err_len_d = 1'b1;
                  state_d   = S_DONE;
               end else begin
                  state_d = S_WAIT_WORD;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // head/enable are registered so they line up with the cycles spent in SHIFT
      en_d   = (state_d == S_SHIFT);
      head_d = en_d & shreg_d[0];
   end

   always_ff @(posedge prog_clk) begin
      if (!pReset) begin
         state_q    <= S_IDLE;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         word_cnt_q <= '0;
         last_q     <= 1'b0;
         err_len_q  <= 1'b0;
         err_tail_q <= 1'b0;
         head_q     <= 1'b0;
         en_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         word_cnt_q <= word_cnt_d;
         last_q     <= last_d;
         err_len_q  <= err_len_d;
         err_tail_q <= err_tail_d;
         head_q     <= head_d;
         en_q       <= en_d;
      end
   end

   assign cfg_ready = (state_q == S_WAIT_WORD);
   assign busy      = (state_q == S_WAIT_WORD) || (state_q == S_SHIFT);
   assign done      = (state_q == S_DONE);
   assign ccff_head = head_q;
   assign chain_en  = en_q;
   assign err_len   = err_len_q;
   assign err_tail  = err_tail_q;
   assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: a bit-stream reference model queues expected head bits,
// a negedge monitor pops and compares them while a chain model checks the final image.
module tb_ccff_bitstream_loader;

   localparam int DW = 32;
   localparam int CL = 36;
   localparam int CW = 16;

   logic          prog_clk  = 1'b0;
   logic          pReset    = 1'b0;
   logic          start     = 1'b0;
   logic          cfg_valid = 1'b0;
   logic          cfg_last  = 1'b0;
   logic [DW-1:0] cfg_data  = '0;
   logic          cfg_ready, ccff_head, chain_en, ccff_tail;
   logic          busy, done, err_len, err_tail;
   logic [CW-1:0] bit_cnt;

   logic [CL-1:0] chain = '0;
   logic          fault_en = 1'b0;
   int            shifts_seen = 0;
   int            errors = 0;
   int            checks = 0;

   bit            exp_q[$];
   logic [CL-1:0] m_img = '0;
   int            m_bits = 0;
   logic          m_last = 1'b0;
   logic [CL-1:0] nom_img;

   always #5 prog_clk = ~prog_clk;

   ccff_bitstream_loader #(.DATA_WIDTH(DW), .CHAIN_LEN(CL), .CNT_W(CW)) dut (
      .prog_clk (prog_clk),
      .pReset   (pReset),
      .start    (start),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_data (cfg_data),
      .cfg_last (cfg_last),
      .ccff_head(ccff_head),
      .chain_en (chain_en),
      .ccff_tail(ccff_tail),
      .busy     (busy),
      .done     (done),
      .err_len  (err_len),
      .err_tail (err_tail),
      .bit_cnt  (bit_cnt)
   );

   // target chain: head enters flop 0, flop CL-1 drives the tail
   always @(posedge prog_clk) begin
      if (!pReset)       chain <= '0;
      else if (chain_en) chain <= {chain[CL-2:0], ccff_head};
   end

   // fault injection forces the tail high during the 5th shift cycle
   assign ccff_tail = chain[CL-1] | (fault_en & chain_en & (shifts_seen == 5));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   always @(negedge prog_clk) begin
      if (start) shifts_seen = 0;
      if (chain_en) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_shift actual=chain_en=1 required=no shift (bit_cnt=%0d)", bit_cnt);
         end else begin
            chk("ccff_head", 64'(ccff_head), 64'(exp_q.pop_front()));
         end
         chk("bit_cnt_during_shift", 64'(bit_cnt), 64'(shifts_seen));
         chk("err_tail_during_shift", 64'(err_tail), 64'(fault_en && shifts_seen >= 5));
         chk("cfg_ready_during_shift", 64'(cfg_ready), 64'(0));
         shifts_seen++;
      end
   end

   // caller is at posedge+1; returns at posedge+1 with reset released
   task automatic do_reset();
      pReset    = 1'b0;
      start     = 1'b0;
      cfg_valid = 1'b0;
      fault_en  = 1'b0;
      @(posedge prog_clk);
      @(negedge prog_clk);
      exp_q.delete();
      m_img  = '0;
      m_bits = 0;
      m_last = 1'b0;
      chk("rst_cfg_ready", 64'(cfg_ready), 64'(0));
      chk("rst_ccff_head", 64'(ccff_head), 64'(0));
      chk("rst_chain_en",  64'(chain_en),  64'(0));
      chk("rst_busy",      64'(busy),      64'(0));
      chk("rst_done",      64'(done),      64'(0));
      chk("rst_err_len",   64'(err_len),   64'(0));
      chk("rst_err_tail",  64'(err_tail),  64'(0));
      chk("rst_bit_cnt",   64'(bit_cnt),   64'(0));
      @(posedge prog_clk); #1;
      pReset = 1'b1;
   endtask

   task automatic start_load();
      start = 1'b1;
      @(posedge prog_clk); #1;
      start  = 1'b0;
      m_bits = 0;
   endtask

   task automatic send_word(input logic [DW-1:0] d, input logic l, input int stall,
                            input int budget, output bit acc);
      bit rdy;
      int n;
      rdy = 1'b0;
      if (stall > 0) begin
         for (int c = 0; c < budget && !rdy; c++) begin
            @(negedge prog_clk);
            rdy = cfg_ready;
            if (rdy) chk("chain_en_in_stall", 64'(chain_en), 64'(0));
            @(posedge prog_clk); #1;
         end
         chk("ready_before_stall", 64'(rdy), 64'(1));
         for (int s = 1; s < stall; s++) begin
            @(negedge prog_clk);
            chk("chain_en_in_stall", 64'(chain_en), 64'(0));
            chk("ready_in_stall", 64'(cfg_ready), 64'(1));
            @(posedge prog_clk); #1;
         end
      end
      cfg_valid = 1'b1;
      cfg_data  = d;
      cfg_last  = l;
      acc       = 1'b0;
      for (int c = 0; c < budget && !acc; c++) begin
         @(negedge prog_clk);
         acc = cfg_ready;
         if (acc) begin
            n = (CL - m_bits < DW) ? (CL - m_bits) : DW;
            for (int k = 0; k < n; k++) begin
               exp_q.push_back(d[k]);
               m_img = {m_img[CL-2:0], d[k]};
            end
            m_bits += n;
            m_last  = l;
         end
         @(posedge prog_clk); #1;
      end
      cfg_valid = 1'b0;
   endtask

   task automatic finish_load();
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 300 && !seen; c++) begin
         @(negedge prog_clk);
         seen = done;
      end
      chk("done",          64'(seen),         64'(1));
      chk("err_len",       64'(err_len),      64'(!(m_bits == CL && m_last)));
      chk("err_tail",      64'(err_tail),     64'(fault_en));
      chk("bit_cnt_final", 64'(bit_cnt),      64'(m_bits));
      chk("shift_count",   64'(shifts_seen),  64'(m_bits));
      chk("busy_done",     64'(busy),         64'(0));
      chk("chain_en_done", 64'(chain_en),     64'(0));
      chk("ready_done",    64'(cfg_ready),    64'(0));
      chk("queue_drained", 64'(exp_q.size()), 64'(0));
      chk("chain_image",   64'(chain),        64'(m_img));
      @(posedge prog_clk); #1;
   endtask

   initial begin
      bit            acc;
      logic [DW-1:0] w0, w1;
      logic          l0, l1;
      int            st;

      do_reset();

      // nominal two-word load
      start_load();
      send_word(32'hA5A5_F00F, 1'b0, 0, 100, acc);
      chk("nom_word0_accepted", 64'(acc), 64'(1));
      send_word(32'h0000_0009, 1'b1, 0, 100, acc);
      chk("nom_word1_accepted", 64'(acc), 64'(1));
      finish_load();
      nom_img = m_img;

      // same words with a 10-cycle stall between them
      do_reset();
      start_load();
      send_word(32'hA5A5_F00F, 1'b0, 0, 100, acc);
      send_word(32'h0000_0009, 1'b1, 10, 100, acc);
      finish_load();
      chk("stall_image_matches_nominal", 64'(chain), 64'(nom_img));

      // short bitstream: only one word, flagged last
      do_reset();
      start_load();
      send_word(32'h1234_5678, 1'b1, 0, 100, acc);
      finish_load();

      // long bitstream: second word not last, third must be refused
      do_reset();
      start_load();
      send_word(32'hDEAD_BEEF, 1'b0, 0, 100, acc);
      send_word(32'h0000_000F, 1'b0, 0, 100, acc);
      send_word(32'hFFFF_FFFF, 1'b1, 0, 20, acc);
      chk("third_word_refused", 64'(acc), 64'(0));
      finish_load();

      // tail fault, then a restart from DONE clears the sticky flags
      do_reset();
      fault_en = 1'b1;
      start_load();
      send_word(32'h0F0F_3C3C, 1'b0, 0, 100, acc);
      send_word(32'h0000_0006, 1'b1, 0, 100, acc);
      finish_load();
      start_load();
      @(negedge prog_clk);
      chk("restart_err_tail_cleared", 64'(err_tail),  64'(0));
      chk("restart_err_len_cleared",  64'(err_len),   64'(0));
      chk("restart_done_low",         64'(done),      64'(0));
      chk("restart_ready",            64'(cfg_ready), 64'(1));
      chk("restart_bit_cnt",          64'(bit_cnt),   64'(0));
      @(posedge prog_clk); #1;

      // reset after 20 shifts, then a clean reload
      do_reset();
      start_load();
      send_word(32'($urandom()), 1'b0, 0, 100, acc);
      for (int c = 0; c < 200 && shifts_seen < 20; c++) @(negedge prog_clk);
      chk("mid_load_reached_20", 64'(shifts_seen >= 20), 64'(1));
      @(posedge prog_clk); #1;
      do_reset();
      start_load();
      send_word(32'($urandom()), 1'b0, 0, 100, acc);
      send_word(32'($urandom()), 1'b1, 0, 100, acc);
      finish_load();

      // randomized loads: random data, framing and stall length
      for (int t = 0; t < 8; t++) begin
         w0 = 32'($urandom());
         w1 = 32'($urandom());
         l0 = ($urandom_range(0, 3) == 0);
         l1 = ($urandom_range(0, 3) != 0);
         st = $urandom_range(0, 4);
         do_reset();
         start_load();
         send_word(w0, l0, 0, 100, acc);
         if (!l0) send_word(w1, l1, st, 100, acc);
         finish_load();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish (checks=%0d errors=%0d)", checks, errors);
      $fatal(1);
   end

endmodule
